// File: rtl/image_downsample.sv
// Crops a square ROI from a raster camera stream and box-averages each BLKxBLK tile into a 28x28 image memory.
// Define INVERT_EN to write 8'hFF-avg (white-on-black output) instead of the plain average.
module image_downsample #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int ROI_X    = 208,
    parameter int ROI_Y    = 128,
    parameter int BLK_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       pix_vld,
    input  logic       pix_sof,
    input  logic [7:0] pix_data,
    output logic       we,
    output logic [9:0] waddr,
    output logic [7:0] wdata,
    output logic       busy,
    output logic       done
);

    localparam int BLK   = 1 << BLK_LOG2;
    localparam int ROI_W = 28 * BLK;
    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 1);
    localparam int AW    = 8 + 2 * BLK_LOG2;
    localparam int NPIX  = 784;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_LO   = XW'(ROI_X);
    localparam logic [XW-1:0] X_HI   = XW'(ROI_X + ROI_W);
    localparam logic [YW-1:0] Y_LO   = YW'(ROI_Y);
    localparam logic [YW-1:0] Y_HI   = YW'(ROI_Y + ROI_W);
    localparam logic [BLK_LOG2-1:0] L_LAST = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] acc [28];
    logic [9:0]    wcnt;
    logic          fin;

    logic          take;
    logic          in_roi;
    logic          first;
    logic          last;
    logic          emit;
    logic [XW-1:0] cx;
    logic [XW-1:0] dx;
    logic [XW-1:0] nx;
    logic [YW-1:0] cy;
    logic [YW-1:0] dy;
    logic [YW-1:0] ny;
    logic [4:0]    col;
    logic [4:0]    row;
    logic [AW-1:0] sum;
    logic [7:0]    avg;
    logic [7:0]    wval;
    logic [9:0]    wbase;

    assign busy = (state == S_ARMED) || (state == S_CAPTURE);

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        // A sof pixel is position (0,0) regardless of the counters: it starts or restarts the frame.
        // Once the final write is in flight (fin), further pixels of this frame are ignored.
        take   = pix_vld && (((state == S_ARMED) && pix_sof) || ((state == S_CAPTURE) && !fin));
        cx     = pix_sof ? '0 : x;
        cy     = pix_sof ? '0 : y;
        dx     = cx - X_LO;
        dy     = cy - Y_LO;
        in_roi = (cx >= X_LO) && (cx < X_HI) && (cy >= Y_LO) && (cy < Y_HI);
        col    = 5'(dx >> BLK_LOG2);
        row    = 5'(dy >> BLK_LOG2);
        first  = (dx[BLK_LOG2-1:0] == '0) && (dy[BLK_LOG2-1:0] == '0);
        last   = (dx[BLK_LOG2-1:0] == L_LAST) && (dy[BLK_LOG2-1:0] == L_LAST);
        sum    = (first ? '0 : acc[col]) + AW'(pix_data);
        avg    = sum[AW-1 -: 8];
        emit   = take && in_roi && last;
        wbase  = pix_sof ? '0 : wcnt;
        nx     = (cx == X_LAST) ? '0 : cx + XW'(1);
        ny     = (cx == X_LAST) ? cy + YW'(1) : cy;
`ifdef INVERT_EN
        wval   = 8'hFF - avg;
`else
        wval   = avg;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            wcnt  <= '0;
            fin   <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            done  <= 1'b0;
            // NOTE: the 28 column accumulators are plain flops, small enough to clear on reset.
            for (int i = 0; i < 28; i++) acc[i] <= '0;
        end else begin
            we   <= emit;
            fin  <= emit && (wbase == 10'(NPIX - 1));
            done <= 1'b0;
            if (emit) begin
                waddr <= 10'(row) * 10'd28 + 10'(col);
                wdata <= wval;
            end
            if (take) begin
                x    <= nx;
                y    <= ny;
                wcnt <= wbase + (emit ? 10'd1 : 10'd0);
                if (in_roi) acc[col] <= sum;
            end
            case (state)
                S_IDLE:    if (capture) state <= S_ARMED;
                S_ARMED:   if (pix_vld && pix_sof) state <= S_CAPTURE;
                S_CAPTURE: if (fin) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_downsample.sv
// Scoreboard bench for image_downsample on a reduced 64x60 frame with 2x2 tiles (56x56 ROI).
// Expected writes are queued as the stimulus sends each tile's last pixel; a monitor pops them on we.
module tb_image_downsample;

    localparam int TW  = 64;
    localparam int TH  = 60;
    localparam int RX  = 4;
    localparam int RY  = 2;
    localparam int BL2 = 1;
    localparam int RW  = 28 * (1 << BL2);

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       capture;
    logic       pix_vld;
    logic       pix_sof;
    logic [7:0] pix_data;
    logic       we;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;

    int  checks;
    int  errors;
    int  done_seen;
    int  done_exp;
    wr_t q [$];
    logic prev_vld;
    logic prev_we;

    image_downsample #(
        .IMG_W(TW), .IMG_H(TH), .ROI_X(RX), .ROI_Y(RY), .BLK_LOG2(BL2)
    ) dut (
        .clk(clk), .rst(rst), .capture(capture), .pix_vld(pix_vld), .pix_sof(pix_sof),
        .pix_data(pix_data), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_roi(input int x, input int y);
        return (x >= RX) && (x < RX + RW) && (y >= RY) && (y < RY + RW);
    endfunction

    // Pixel patterns; inside the ROI r/c are the tile coords, lx/ly the position within the tile.
    function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
        int r, c, lx, ly;
        bit roi;
        roi = in_roi(x, y);
        r  = (y - RY) / 2;
        c  = (x - RX) / 2;
        lx = (x - RX) % 2;
        ly = (y - RY) % 2;
        case (mode)
            0: return 8'h80;
            1: return roi ? 8'h40 : 8'hFF;
            2: if (!roi) return 8'h33;
               else if (r == 5 && c == 9) return (lx == 0 && ly == 0) ? 8'h00 : 8'h01;
               else return 8'((r + c) * 4);
            3: return roi ? 8'(r * 3 + c) : 8'h10;
            default: return roi ? 8'(r + c + ly * 2 + lx) : 8'h00;
        endcase
    endfunction

    // Hand-derived tile averages: mode 2 special tile is 3/4 -> 0, mode 4 is (4(r+c)+6)/4 -> r+c+1.
    function automatic logic [7:0] exp_val(input int mode, input int r, input int c);
        logic [7:0] v;
        case (mode)
            0: v = 8'h80;
            1: v = 8'h40;
            2: v = (r == 5 && c == 9) ? 8'h00 : 8'((r + c) * 4);
            3: v = 8'(r * 3 + c);
            default: v = 8'(r + c + 1);
        endcase
`ifdef INVERT_EN
        return 8'hFF - v;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_vld  = 1'b0;
        pix_sof  = 1'b0;
        pix_data = 8'hAA;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic sof, input logic [7:0] d, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 99) < 30) begin
                pix_vld  = 1'b0;
                pix_sof  = 1'b0;
                pix_data = 8'hAA;
                step();
            end
        end
        pix_vld  = 1'b1;
        pix_sof  = sof;
        pix_data = d;
        step();
    endtask

    task automatic do_capture();
        capture = 1'b1;
        step();
        capture = 1'b0;
        check("busy_armed", busy, 1'b1);
    endtask

    task automatic run_frame(input int mode, input bit gaps, input int lines, input bit expw);
        wr_t e;
        for (int yy = 0; yy < lines; yy++) begin
            for (int xx = 0; xx < TW; xx++) begin
                if (expw && in_roi(xx, yy) && ((xx - RX) % 2 == 1) && ((yy - RY) % 2 == 1)) begin
                    e.a = 10'(((yy - RY) / 2) * 28 + (xx - RX) / 2);
                    e.d = exp_val(mode, (yy - RY) / 2, (xx - RX) / 2);
                    q.push_back(e);
                end
                drive(xx == 0 && yy == 0, pix_val(mode, xx, yy), gaps);
            end
        end
        pix_vld = 1'b0;
        pix_sof = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (we) begin
            check("write_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("waddr", waddr, e.a);
                check("wdata", wdata, e.d);
            end
            check("we_after_pixel", prev_vld, 1'b1);
        end
        if (done) begin
            done_seen++;
            check("done_after_last_we", {prev_we, q.size() == 0}, 2'b11);
        end
        prev_vld = pix_vld;
        prev_we  = we;
    end

    initial begin
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        done_exp  = 0;
        prev_vld  = 1'b0;
        prev_we   = 1'b0;
        rst       = 1'b1;
        capture   = 1'b0;
        pix_vld   = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 8'h00;
        repeat (3) step();
        check("rst_we", we, 1'b0);
        check("rst_waddr", waddr, 10'd0);
        check("rst_wdata", wdata, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        idle(2);

        // Flat frame, ROI/background contrast, per-tile mapping with truncation.
        for (int m = 0; m < 3; m++) begin
            do_capture();
            run_frame(m, 1'b0, TH, 1'b1);
            done_exp++;
            idle(5);
            check("idle_after_frame", busy, 1'b0);
        end

        // Flat frame with random stalls.
        do_capture();
        run_frame(0, 1'b1, TH, 1'b1);
        done_exp++;
        idle(5);

        // Restart on a second sof mid-capture: first frame's writes are overwritten by the second.
        do_capture();
        run_frame(0, 1'b0, 30, 1'b1);
        run_frame(3, 1'b0, TH, 1'b1);
        done_exp++;
        idle(5);

        // Reset after ~300 writes aborts the capture; a later frame without capture is ignored.
        do_capture();
        run_frame(4, 1'b0, 24, 1'b1);
        rst = 1'b1;
        step();
        check("abort_we", we, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        rst = 1'b0;
        run_frame(4, 1'b0, TH, 1'b0);
        idle(3);
        check("ignored_busy", busy, 1'b0);

        // capture together with sof only arms; non-sof pixels in ARMED are ignored.
        capture  = 1'b1;
        pix_vld  = 1'b1;
        pix_sof  = 1'b1;
        pix_data = 8'hEE;
        step();
        capture = 1'b0;
        pix_sof = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b0, 8'hEE, 1'b0);
        check("armed_wait_sof", busy, 1'b1);
        run_frame(4, 1'b0, TH, 1'b1);
        done_exp++;
        idle(5);

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("queue_drained", q.size(), 0);
        check("done_count", done_seen, done_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
